// File: rtl/pcs_scrambler.sv
// 10GBASE-R 64b/66b transmit scrambler (x^58 + x^39 + 1) with a 2-entry skid buffer.
// Optional header check enabled by defining SCRAMBLER_HDR_CHECK_EN.
module pcs_scrambler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_encoded_data_valid,
    input  logic [DATA_WIDTH-1:0] i_encoded_data,
    input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
    output logic                  o_scrambler_trdy,
    input  logic                  i_gearbox_trdy,
    output logic                  o_scrambled_data_valid,
    output logic [DATA_WIDTH-1:0] o_scrambled_data,
    output logic [HDR_WIDTH-1:0]  o_sync_hdr,
    output logic                  o_block_start,
    output logic                  o_hdr_err
);

    localparam int unsigned LFSR_W = 58;
    localparam int unsigned TAP_A  = 38;
    localparam int unsigned TAP_B  = 57;

    logic [LFSR_W-1:0]     lfsr_q;
    logic [LFSR_W-1:0]     lfsr_nxt_c;
    logic [DATA_WIDTH-1:0] scr_c;
    logic                  phase_q;
    logic [HDR_WIDTH-1:0]  hdr_q;
    logic                  trdy_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [HDR_WIDTH-1:0]  out_hdr_q;
    logic                  out_start_q;

    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [HDR_WIDTH-1:0]  skid_hdr_q;
    logic                  skid_start_q;

    logic                  accept_c;
    logic                  xfer_c;
    logic                  out_free_c;
    logic                  load_out_skid_c;
    logic                  load_out_new_c;
    logic                  load_skid_c;
    logic                  out_valid_d_c;
    logic                  skid_valid_d_c;
    logic [HDR_WIDTH-1:0]  beat_hdr_c;
    logic                  beat_start_c;

    // Bit-serial scrambler unrolled across the beat, bit 0 first.
    always_comb begin : scramble
        logic [LFSR_W-1:0] s;
        s     = lfsr_q;
        scr_c = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            scr_c[i] = i_encoded_data[i] ^ s[TAP_A] ^ s[TAP_B];
            s        = {s[LFSR_W-2:0], scr_c[i]};
        end
        lfsr_nxt_c = s;
    end

    assign accept_c     = i_encoded_data_valid && trdy_q;
    assign xfer_c       = out_valid_q && i_gearbox_trdy;
    assign beat_hdr_c   = phase_q ? hdr_q : i_sync_hdr;
    assign beat_start_c = !phase_q;

    // Skid steering: the output register always holds the oldest beat.
    always_comb begin
        out_free_c      = !out_valid_q || xfer_c;
        load_out_skid_c = out_free_c && skid_valid_q;
        load_out_new_c  = out_free_c && !skid_valid_q && accept_c;
        load_skid_c     = accept_c && !load_out_new_c;
        out_valid_d_c   = load_out_skid_c || load_out_new_c || (out_valid_q && !xfer_c);
        skid_valid_d_c  = load_skid_c || (skid_valid_q && !load_out_skid_c);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q  <= '1;
            phase_q <= 1'b0;
            hdr_q   <= '0;
        end else if (accept_c) begin
            lfsr_q  <= lfsr_nxt_c;
            phase_q <= !phase_q;
            if (!phase_q) begin
                hdr_q <= i_sync_hdr;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            trdy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_hdr_q    <= '0;
            out_start_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_hdr_q   <= '0;
            skid_start_q <= 1'b0;
        end else begin
            trdy_q       <= !skid_valid_d_c;
            out_valid_q  <= out_valid_d_c;
            skid_valid_q <= skid_valid_d_c;
            if (load_out_skid_c) begin
                out_data_q  <= skid_data_q;
                out_hdr_q   <= skid_hdr_q;
                out_start_q <= skid_start_q;
            end else if (load_out_new_c) begin
                out_data_q  <= scr_c;
                out_hdr_q   <= beat_hdr_c;
                out_start_q <= beat_start_c;
            end
            if (load_skid_c) begin
                skid_data_q  <= scr_c;
                skid_hdr_q   <= beat_hdr_c;
                skid_start_q <= beat_start_c;
            end
        end
    end

`ifdef SCRAMBLER_HDR_CHECK_EN
    logic beat_err_c;
    logic out_err_q;
    logic skid_err_q;

    // 00/11 are not legal 64b/66b sync headers; flag travels with the first beat.
    assign beat_err_c = !phase_q && ((i_sync_hdr == '0) || (i_sync_hdr == '1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_err_q  <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            if (load_out_skid_c) begin
                out_err_q <= skid_err_q;
            end else if (load_out_new_c) begin
                out_err_q <= beat_err_c;
            end
            if (load_skid_c) begin
                skid_err_q <= beat_err_c;
            end
        end
    end

    assign o_hdr_err = out_err_q;
`else
    assign o_hdr_err = 1'b0;
`endif

    assign o_scrambler_trdy       = trdy_q;
    assign o_scrambled_data_valid = out_valid_q;
    assign o_scrambled_data       = out_data_q;
    assign o_sync_hdr             = out_hdr_q;
    assign o_block_start          = out_start_q;

endmodule

// File: doc/pcs_scrambler.md
# pcs_scrambler

Self-synchronizing 64b/66b transmit scrambler (polynomial x^58 + x^39 + 1) for the 10GBASE-R PCS transmit path. Sits directly downstream of the XGMII 64b/66b encoder and upstream of the TX gearbox. Accepts 32-bit encoded beats (two beats per 66-bit block) with the 2-bit sync header, scrambles the payload and passes the header unscrambled. A registered 2-entry skid buffer decouples upstream ready from downstream backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, payload beat width; only 32 is supported.
- HDR_WIDTH, 2, sync header width.

Ports:
- i_clk  in  1  single clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_encoded_data_valid  in  1  input beat valid.
- i_encoded_data  in  DATA_WIDTH  encoded payload beat, bit 0 transmitted first.
- i_sync_hdr  in  HDR_WIDTH  sync header; sampled on the first beat of a block only.
- o_scrambler_trdy  out  1  ready to accept an input beat.
- i_gearbox_trdy  in  1  downstream ready.
- o_scrambled_data_valid  out  1  output beat valid.
- o_scrambled_data  out  DATA_WIDTH  scrambled payload beat.
- o_sync_hdr  out  HDR_WIDTH  header of the current block, held on both beats.
- o_block_start  out  1  high on the first beat of a block.
- o_hdr_err  out  1  invalid header flag (see Configuration).

## Operation
- Input accept: i_encoded_data_valid && o_scrambler_trdy. Output transfer: o_scrambled_data_valid && i_gearbox_trdy.
- Beat phase: a 1-bit toggle advanced on each accepted beat; 0 = first beat (header sampled, o_block_start=1), 1 = second beat (header reused from the first beat).
- LFSR: 58-bit state s, reset to all ones. For i = 0..31 in order: out[i] = d[i] ^ s[38] ^ s[57]; s = {s[56:0], out[i]}. State advances only on accepted beats. The header is never scrambled.
- Buffer: output register plus one skid register, depth 2. o_scrambler_trdy = !skid_full, registered. Accepted beats enter the output register when it is empty or being drained in the same cycle; otherwise they enter the skid register. Order is strictly preserved; no beat is dropped or duplicated.
- Simultaneous accept and transfer with both entries occupied: the skid entry moves to the output register and the new beat enters the skid register only if trdy was high that cycle.
- Reset (at any time, including mid-block): phase=0, LFSR=all ones, both entries empty, all outputs 0, o_scrambler_trdy=0 while i_reset is asserted and 1 on the first clock after release.

## Timing
- Latency: 1 cycle from input accept to o_scrambled_data_valid with an empty buffer.
- Throughput: 1 beat/cycle sustained while i_gearbox_trdy=1.
- o_scrambler_trdy falls the cycle after the second entry fills and rises the cycle after an entry drains.
- o_scrambled_data, o_sync_hdr, o_block_start and o_hdr_err are stable while o_scrambled_data_valid=1 and i_gearbox_trdy=0.
- Reset values: o_scrambled_data_valid=0, o_scrambled_data=0, o_sync_hdr=0, o_block_start=0, o_hdr_err=0, o_scrambler_trdy=0.

## Configuration
- SCRAMBLER_HDR_CHECK_EN defined: a header of 2'b00 or 2'b11 on a first beat sets o_hdr_err=1 on that block's first output beat (one-beat flag travelling with the data). The header and payload are passed through unchanged.
- Not defined: o_hdr_err is tied to 0 and no check logic exists.

## Test plan
- Reset: assert i_reset for 3 cycles, then release -> all outputs 0 during reset; o_scrambler_trdy=1 one cycle after release.
- Zero block: after reset, send payload 0x00000000, 0x00000000 with hdr 2'b01 and i_gearbox_trdy=1 -> output beats 32'h00000000 then 32'h03FFFF80, o_sync_hdr=01 on both beats, o_block_start=1,0.
- Backpressure: stream 8 beats with i_gearbox_trdy=0 for cycles 2-4 -> o_scrambler_trdy drops after 2 buffered beats; output sequence is identical to the unstalled run; no loss or duplication.
- Random 200 blocks with random ready on both sides -> bench descrambler recovers every input payload and header exactly.
- With SCRAMBLER_HDR_CHECK_EN: hdr 2'b11 -> o_hdr_err=1 on that block's first output beat only, header 11 passed through; without the macro, o_hdr_err stays 0.
- Reset after the first beat of a block, then repeat the zero-block test -> the next beat is treated as a first beat and produces 32'h00000000, 32'h03FFFF80 again.
